// File: rtl/axis_fifo_video_tx.sv
// Drains a show-ahead pixel FIFO into an AXI4-Stream video master with SOF/EOL framing,
// frame-complete pulse and a saturating mid-frame underrun counter.
module axis_fifo_video_tx #(
    parameter int unsigned WIDTH    = 24,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned UFL_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tuser,
    output logic             m_axis_tlast,
    output logic             frame_done,
    output logic [UFL_W-1:0] ufl_count
);

    localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          eof_q;
    logic          free;
    logic          pop;
    logic          mid_frame;
    logic          underrun;

    always_comb begin
        free       = !m_axis_tvalid || m_axis_tready;
        pop        = enable && !fifo_empty && free && !reset;
        fifo_rd_en = pop;
        mid_frame  = (x != '0) || (y != '0);
        underrun   = enable && free && fifo_empty && mid_frame;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            frame_done    <= 1'b0;
            ufl_count     <= '0;
            eof_q         <= 1'b0;
            x             <= '0;
            y             <= '0;
        end else begin
            // eof_q tags the held beat as the final pixel of the frame
            frame_done <= m_axis_tvalid && m_axis_tready && eof_q;
            if (pop) begin
                m_axis_tdata  <= fifo_dout;
                m_axis_tvalid <= 1'b1;
                m_axis_tuser  <= !mid_frame;
                m_axis_tlast  <= (x == X_LAST);
                eof_q         <= (x == X_LAST) && (y == Y_LAST);
                if (x == X_LAST) begin
                    x <= '0;
                    y <= (y == Y_LAST) ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end else if (free) begin
                m_axis_tvalid <= 1'b0;
            end
            if (underrun && (ufl_count != '1))
                ufl_count <= ufl_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_fifo_video_tx.sv
// Self-checking bench for axis_fifo_video_tx: FIFO + stream scoreboard model, H_ACTIVE=4, V_ACTIVE=2.
module tb_axis_fifo_video_tx;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int HV = H * V;
    localparam int W  = 24;

    typedef struct packed {
        logic [W-1:0] d;
        logic         u;
        logic         l;
        logic         e;
    } beat_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic [W-1:0] fifo_dout = '0;
    logic         fifo_empty = 1'b1;
    logic         m_axis_tready = 1'b0;

    logic         fifo_rd_en, m_axis_tvalid, m_axis_tuser, m_axis_tlast, frame_done;
    logic [W-1:0] m_axis_tdata;
    logic [15:0]  ufl_count;

    logic         rd_en2, tvalid2, tuser2, tlast2, frame_done2;
    logic [W-1:0] tdata2;
    logic [1:0]   ufl_count2;

    axis_fifo_video_tx #(.WIDTH(W), .H_ACTIVE(H), .V_ACTIVE(V), .UFL_W(16)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .frame_done(frame_done), .ufl_count(ufl_count)
    );

    axis_fifo_video_tx #(.WIDTH(W), .H_ACTIVE(H), .V_ACTIVE(V), .UFL_W(2)) dut_sat (
        .clk(clk), .reset(reset), .enable(enable),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(rd_en2),
        .m_axis_tdata(tdata2), .m_axis_tvalid(tvalid2), .m_axis_tready(m_axis_tready),
        .m_axis_tuser(tuser2), .m_axis_tlast(tlast2),
        .frame_done(frame_done2), .ufl_count(ufl_count2)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [W-1:0] fq[$];
    beat_t        expq[$];
    int           pushed_n, pop_n, raw_ufl, fd_seen;
    logic         mv, exp_fd, prev_stall;
    logic [W-1:0] sv_d;
    logic         sv_u, sv_l;

    function automatic void refresh();
        fifo_empty = (fq.size() == 0);
        fifo_dout  = (fq.size() == 0) ? '0 : fq[0];
    endfunction

    // Expected framing comes purely from the pixel's ordinal position since reset
    task automatic push(input logic [W-1:0] d);
        beat_t b;
        fq.push_back(d);
        b.d = d;
        b.u = (pushed_n % HV == 0);
        b.l = (pushed_n % H == H - 1);
        b.e = (pushed_n % HV == HV - 1);
        expq.push_back(b);
        pushed_n++;
        refresh();
    endtask

    task automatic cycle();
        logic  pop_exp, acc, fd_next, mv_next;
        int    exp1, exp2;
        beat_t b;
        @(negedge clk);
        exp1 = raw_ufl;
        exp2 = (raw_ufl > 3) ? 3 : raw_ufl;
        total++;
        if (m_axis_tvalid !== mv) begin
            bad++; $display("FAIL tvalid: got %0b expected %0b", m_axis_tvalid, mv);
        end
        total++;
        if (frame_done !== exp_fd) begin
            bad++; $display("FAIL frame_done: got %0b expected %0b", frame_done, exp_fd);
        end
        if (frame_done === 1'b1) fd_seen++;
        total++;
        if (ufl_count !== 16'(exp1)) begin
            bad++; $display("FAIL ufl_count: got %0d expected %0d", ufl_count, exp1);
        end
        total++;
        if (ufl_count2 !== 2'(exp2)) begin
            bad++; $display("FAIL ufl_count_sat: got %0d expected %0d", ufl_count2, exp2);
        end
        if (prev_stall) begin
            total++;
            if ({m_axis_tdata, m_axis_tuser, m_axis_tlast} !== {sv_d, sv_u, sv_l}) begin
                bad++; $display("FAIL stall_stable: got %0h/%0b/%0b expected %0h/%0b/%0b",
                                m_axis_tdata, m_axis_tuser, m_axis_tlast, sv_d, sv_u, sv_l);
            end
        end
        pop_exp = enable && (fq.size() > 0) && (!mv || m_axis_tready);
        total++;
        if (fifo_rd_en !== pop_exp || rd_en2 !== pop_exp) begin
            bad++; $display("FAIL rd_en: got %0b/%0b expected %0b", fifo_rd_en, rd_en2, pop_exp);
        end
        acc = mv && m_axis_tready;
        fd_next = 1'b0;
        if (acc) begin
            total++;
            if (expq.size() == 0) begin
                bad++; $display("FAIL extra_beat: got %0h expected none", m_axis_tdata);
            end else begin
                b = expq.pop_front();
                fd_next = b.e;
                if ({m_axis_tdata, m_axis_tuser, m_axis_tlast} !== {b.d, b.u, b.l}) begin
                    bad++; $display("FAIL beat: got %0h/%0b/%0b expected %0h/%0b/%0b",
                                    m_axis_tdata, m_axis_tuser, m_axis_tlast, b.d, b.u, b.l);
                end
            end
        end
        if (enable && (!mv || m_axis_tready) && fq.size() == 0 && (pop_n % HV != 0))
            raw_ufl++;
        prev_stall = mv && !m_axis_tready;
        sv_d = m_axis_tdata; sv_u = m_axis_tuser; sv_l = m_axis_tlast;
        mv_next = pop_exp ? 1'b1 : ((!mv || m_axis_tready) ? 1'b0 : mv);
        @(posedge clk);
        #1;
        if (pop_exp) begin
            void'(fq.pop_front());
            pop_n++;
        end
        mv = mv_next;
        exp_fd = fd_next;
        refresh();
    endtask

    // mode 0: hold tready, 1: pattern 1,0,0,1..., 2: random
    task automatic drain(input int maxc, input int mode);
        int n = 0;
        while (expq.size() > 0 && n < maxc) begin
            if (mode == 1) m_axis_tready = ((n % 3) == 0);
            else if (mode == 2) m_axis_tready = 1'($urandom_range(0, 1));
            cycle();
            n++;
        end
        m_axis_tready = 1'b1;
        total++;
        if (expq.size() != 0) begin
            bad++; $display("FAIL drain_timeout: got %0d pending expected 0", expq.size());
        end
        cycle();
        cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        fq.delete();
        expq.delete();
        refresh();
        @(posedge clk);
        #1;
        reset = 1'b0;
        pushed_n = 0; pop_n = 0; raw_ufl = 0; fd_seen = 0;
        mv = 1'b0; exp_fd = 1'b0; prev_stall = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b1;
        m_axis_tready = 1'b1;
        fq.push_back(24'h123456);
        refresh();
        @(negedge clk);
        total++;
        if (fifo_rd_en !== 1'b0) begin
            bad++; $display("FAIL rd_en_in_reset: got %0b expected 0", fifo_rd_en);
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, frame_done, ufl_count, ufl_count2} !== '0) begin
            bad++; $display("FAIL reset_state: got v%0b d%0h u%0b l%0b fd%0b ufl%0d expected all 0",
                            m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, frame_done, ufl_count);
        end
        do_reset();
    endtask

    task automatic test_frame();
        do_reset();
        enable = 1'b1;
        m_axis_tready = 1'b1;
        for (int i = 1; i <= 8; i++) push(W'(i));
        repeat (10) cycle();
        total++;
        if (expq.size() != 0 || fd_seen != 1 || ufl_count !== 16'd0) begin
            bad++; $display("FAIL frame: got pending=%0d fd=%0d ufl=%0d expected 0/1/0",
                            expq.size(), fd_seen, ufl_count);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        enable = 1'b1;
        for (int i = 1; i <= 8; i++) push(W'(i));
        drain(60, 1);
        total++;
        if (fd_seen != 1) begin
            bad++; $display("FAIL bp_frame_done: got %0d expected 1", fd_seen);
        end
    endtask

    task automatic test_underrun();
        do_reset();
        enable = 1'b1;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 3; i++) push(W'($urandom));
        repeat (8) cycle();
        for (int i = 0; i < 5; i++) push(W'($urandom));
        drain(40, 0);
        total++;
        if (ufl_count !== 16'd5 || fd_seen != 1) begin
            bad++; $display("FAIL underrun: got ufl=%0d fd=%0d expected 5/1", ufl_count, fd_seen);
        end
    endtask

    task automatic test_enable_pause();
        do_reset();
        enable = 1'b1;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 8; i++) push(W'($urandom));
        repeat (2) cycle();
        enable = 1'b0;
        repeat (10) cycle();
        total++;
        if (pop_n != 2 || ufl_count !== 16'd0) begin
            bad++; $display("FAIL enable_pause: got pops=%0d ufl=%0d expected 2/0", pop_n, ufl_count);
        end
        enable = 1'b1;
        drain(40, 0);
        total++;
        if (fd_seen != 1) begin
            bad++; $display("FAIL enable_resume_fd: got %0d expected 1", fd_seen);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        enable = 1'b1;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 8; i++) push(W'($urandom));
        repeat (6) cycle();
        do_reset();
        @(negedge clk);
        total++;
        if (m_axis_tvalid !== 1'b0 || ufl_count !== 16'd0) begin
            bad++; $display("FAIL reset_mid: got tvalid=%0b ufl=%0d expected 0/0", m_axis_tvalid, ufl_count);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) push(W'($urandom));
        drain(30, 0);
        total++;
        if (pop_n != 4 || fd_seen != 0) begin
            bad++; $display("FAIL reset_mid_resume: got pops=%0d fd=%0d expected 4/0", pop_n, fd_seen);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        enable = 1'b1;
        m_axis_tready = 1'b1;
        push(W'($urandom));
        push(W'($urandom));
        repeat (9) cycle();
        total++;
        if (ufl_count !== 16'd7 || ufl_count2 !== 2'd3) begin
            bad++; $display("FAIL saturate: got %0d/%0d expected 7/3", ufl_count, ufl_count2);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 3 * HV; i++) push(W'($urandom));
        drain(300, 2);
        total++;
        if (fd_seen != 3) begin
            bad++; $display("FAIL b2b_frames: got %0d expected 3", fd_seen);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_backpressure();
        test_underrun();
        test_enable_pause();
        test_reset_mid_frame();
        test_saturate();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
